// File: rtl/sound_pkg.sv
// Shared types for the sound engine: FSM state encoding and waveform select values.
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MUTED = 2'd2
  } state_t;

  localparam logic WAVE_SQUARE = 1'b0;
  localparam logic WAVE_SAW    = 1'b1;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: wraps modulo 2^ACC_W; clear wins over enable.
module phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/sound_engine.sv
// Prioritised sound-event player: picks the highest-priority request, plays a
// square or sawtooth tone for a fixed number of cycles, with a mute toggle.
module sound_engine
  import sound_pkg::*;
#(
  parameter int NUM_EV = 4,
  parameter int ACC_W  = 16,
  parameter int DAC_W  = 8,
  parameter int DUR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_EV-1:0]         ev_req,
  input  logic [NUM_EV*ACC_W-1:0]   ev_inc,
  input  logic [NUM_EV*DUR_W-1:0]   ev_dur,
  input  logic                      mute_toggle,
  input  logic                      wave_sel,
  output logic [DAC_W-1:0]          dac_out,
  output logic                      playing,
  output logic [$clog2(NUM_EV)-1:0] active_ev,
  output logic                      muted
);

  localparam int IDX_W = $clog2(NUM_EV);

  state_t             state_q, state_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   inc_q, inc_d;
  logic [IDX_W-1:0]   active_q, active_d;
  logic [ACC_W-1:0]   acc;
  logic               acc_clear, acc_en;

  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [ACC_W-1:0]   win_inc;
  logic [DUR_W-1:0]   win_dur;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_inc = '0;
    win_dur = '0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (ev_req[i] && (ev_dur[i*DUR_W +: DUR_W] != '0)) begin
        win_vld = 1'b1;
        win_idx = i[IDX_W-1:0];
        win_inc = ev_inc[i*ACC_W +: ACC_W];
        win_dur = ev_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      inc_q    <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      inc_q    <= inc_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    inc_d     = inc_q;
    active_d  = active_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mute_toggle) begin
          state_d   = ST_MUTED;
          rem_d     = '0;
          acc_clear = 1'b1;
        end else if (win_vld) begin
          state_d   = ST_PLAY;
          inc_d     = win_inc;
          rem_d     = win_dur;
          active_d  = win_idx;
          acc_clear = 1'b1;
        end
      end
      ST_PLAY: begin
        if (mute_toggle) begin
          state_d   = ST_MUTED;
          rem_d     = '0;
          acc_clear = 1'b1;
        end else if (win_vld && (win_idx <= active_q)) begin
          inc_d     = win_inc;
          rem_d     = win_dur;
          active_d  = win_idx;
          acc_clear = 1'b1;
        end else if (rem_q == DUR_W'(1)) begin
          state_d   = ST_IDLE;
          rem_d     = '0;
          acc_clear = 1'b1;
        end else begin
          rem_d     = rem_q - DUR_W'(1);
          acc_en    = 1'b1;
        end
      end
      ST_MUTED: begin
        if (mute_toggle) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rem_d     = '0;
        acc_clear = 1'b1;
      end
    endcase
  end

  always_comb begin
    playing   = (state_q == ST_PLAY);
    muted     = (state_q == ST_MUTED);
    active_ev = active_q;
    dac_out   = '0;
    if (state_q == ST_PLAY) begin
      if (wave_sel == WAVE_SAW) begin
        dac_out = acc[ACC_W-1 -: DAC_W];
      end else begin
        dac_out = {DAC_W{acc[ACC_W-1]}};
      end
    end
  end

  phase_acc #(
    .ACC_W(ACC_W)
  ) u_phase_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .enable (acc_en),
    .inc    (inc_q),
    .acc    (acc)
  );

endmodule

// File: tb/tb_sound_engine.sv
// Directed bench for sound_engine: note timing, priority, wrap, mute and reset.
module tb_sound_engine;

  localparam int NUM_EV = 4;
  localparam int ACC_W  = 16;
  localparam int DAC_W  = 8;
  localparam int DUR_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_EV-1:0]       ev_req;
  logic [NUM_EV*ACC_W-1:0] ev_inc;
  logic [NUM_EV*DUR_W-1:0] ev_dur;
  logic                    mute_toggle;
  logic                    wave_sel;
  logic [DAC_W-1:0]        dac_out;
  logic                    playing;
  logic [1:0]              active_ev;
  logic                    muted;

  int checks   = 0;
  int failures = 0;

  sound_engine #(
    .NUM_EV(NUM_EV), .ACC_W(ACC_W), .DAC_W(DAC_W), .DUR_W(DUR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_req      (ev_req),
    .ev_inc      (ev_inc),
    .ev_dur      (ev_dur),
    .mute_toggle (mute_toggle),
    .wave_sel    (wave_sel),
    .dac_out     (dac_out),
    .playing     (playing),
    .active_ev   (active_ev),
    .muted       (muted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s ok obs=%0h", tag, obs);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later; pulse inputs drop afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    ev_req      = '0;
    mute_toggle = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] dac, input logic ply,
                            input logic [1:0] act, input logic mt);
    check({tag, ".dac"},     32'(dac_out),   32'(dac));
    check({tag, ".playing"}, 32'(playing),   32'(ply));
    check({tag, ".active"},  32'(active_ev), 32'(act));
    check({tag, ".muted"},   32'(muted),     32'(mt));
  endtask

  initial begin
    rst = 1'b1; ev_req = '0; ev_inc = '0; ev_dur = '0;
    mute_toggle = 1'b0; wave_sel = 1'b1;
    step(); step();
    check_outs("reset", 8'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Basic sawtooth note, channel 0, 5 cycles
    ev_inc[0*ACC_W +: ACC_W] = 16'h1000;
    ev_dur[0*DUR_W +: DUR_W] = 8'd5;
    ev_req = 4'b0001;
    step();
    check_outs("saw0", 8'h00, 1'b1, 2'd0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      step();
      check($sformatf("saw%0d.dac", k), 32'(dac_out), 32'(k * 16));
      check($sformatf("saw%0d.playing", k), 32'(playing), 32'd1);
    end
    step();
    check_outs("saw_end", 8'h00, 1'b0, 2'd0, 1'b0);

    // Priority, lower-priority drop, higher-priority restart
    ev_inc[1*ACC_W +: ACC_W] = 16'h0100; ev_dur[1*DUR_W +: DUR_W] = 8'd10;
    ev_inc[2*ACC_W +: ACC_W] = 16'h0200; ev_dur[2*DUR_W +: DUR_W] = 8'd10;
    ev_inc[3*ACC_W +: ACC_W] = 16'h0300; ev_dur[3*DUR_W +: DUR_W] = 8'd10;
    ev_req = 4'b0110;
    step();
    check_outs("prio_start", 8'h00, 1'b1, 2'd1, 1'b0);
    step();
    check_outs("prio_run", 8'h01, 1'b1, 2'd1, 1'b0);
    ev_req = 4'b1000;
    step();
    check_outs("prio_low_drop", 8'h02, 1'b1, 2'd1, 1'b0);
    ev_req = 4'b0001;
    step();
    check_outs("prio_restart", 8'h00, 1'b1, 2'd0, 1'b0);
    step();
    check_outs("prio_restart_run", 8'h10, 1'b1, 2'd0, 1'b0);
    repeat (3) step();
    check_outs("prio_last", 8'h40, 1'b1, 2'd0, 1'b0);
    step();
    check_outs("prio_end", 8'h00, 1'b0, 2'd0, 1'b0);

    // Square wave with accumulator wrap
    wave_sel = 1'b0;
    ev_inc[0*ACC_W +: ACC_W] = 16'h8000;
    ev_dur[0*DUR_W +: DUR_W] = 8'd4;
    ev_req = 4'b0001;
    step(); check("sq0", 32'(dac_out), 32'h00);
    step(); check("sq1", 32'(dac_out), 32'hFF);
    step(); check("sq2", 32'(dac_out), 32'h00);
    step(); check("sq3", 32'(dac_out), 32'hFF);
    step();
    check_outs("sq_end", 8'h00, 1'b0, 2'd0, 1'b0);

    // Mute beats a same-cycle request; requests ignored while muted
    ev_req = 4'b0001; mute_toggle = 1'b1;
    step();
    check_outs("mute_enter", 8'h00, 1'b0, 2'd0, 1'b1);
    ev_req = 4'b0001;
    step();
    check_outs("mute_ignore", 8'h00, 1'b0, 2'd0, 1'b1);
    mute_toggle = 1'b1;
    step();
    check_outs("mute_exit", 8'h00, 1'b0, 2'd0, 1'b0);

    // Zero-duration request dropped; a non-zero lower-priority one then wins
    ev_dur[0*DUR_W +: DUR_W] = 8'd0;
    ev_req = 4'b0001;
    step();
    check_outs("zero_dur", 8'h00, 1'b0, 2'd0, 1'b0);
    ev_req = 4'b0011;
    step();
    check("zero_dur_fallthrough.playing", 32'(playing), 32'd1);
    check("zero_dur_fallthrough.active", 32'(active_ev), 32'd1);

    // Mute mid-note aborts it
    mute_toggle = 1'b1;
    step();
    check_outs("mute_mid_note", 8'h00, 1'b0, 2'd1, 1'b1);
    mute_toggle = 1'b1;
    step();

    // Reset mid-note
    wave_sel = 1'b1;
    ev_inc[2*ACC_W +: ACC_W] = 16'h3000;
    ev_req = 4'b0100;
    step(); step();
    check_outs("pre_rst", 8'h30, 1'b1, 2'd2, 1'b0);
    rst = 1'b1;
    step();
    check_outs("rst_mid_note", 8'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Reset while muted
    mute_toggle = 1'b1;
    step();
    check("pre_rst_muted", 32'(muted), 32'd1);
    rst = 1'b1;
    step();
    check_outs("rst_muted", 8'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
